// File: rtl/simon32_64_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : simon32_64_pipe
// Description : Fully pipelined SIMON 32/64 encryptor. Each pipeline stage
//               carries {x, y, k3, k2, k1, k0} and applies 32/NumStages
//               rounds, expanding the key window on the fly, so a new
//               (plaintext, key) pair can enter on every clock.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module simon32_64_pipe #(
   parameter int NumStages = 32   // legal: 1, 2, 4, 8, 16, 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] plaintext,
   input  logic [63:0] key,
   output logic [31:0] ciphertext
);

   localparam int c_ROUNDS_PER_STAGE = 32 / NumStages;

   // z0 written left to right, so sequence bit i sits at vector index 61-i
   localparam logic [61:0] c_Z0 =
      62'b11111010001001010110000111001101111101000100101011000011100110;

   // One round on the packed state {x, y, k3, k2, k1, k0}. The window holds
   // k_i..k_{i+3}; after the round it holds k_{i+1}..k_{i+4}. Keys produced
   // by the last four rounds are never consumed, so z_bit is irrelevant there.
   function automatic logic [95:0] round_step(input logic [95:0] st, input logic z_bit);
      logic [15:0] x, y, k0, k1, k3, f, tmp, k4;
      x   = st[95:80];
      y   = st[79:64];
      k3  = st[63:48];
      k1  = st[31:16];
      k0  = st[15:0];
      f   = ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
      tmp = {k3[2:0], k3[15:3]} ^ k1;
      tmp = tmp ^ {tmp[0], tmp[15:1]};
      k4  = 16'hFFFC ^ {15'd0, z_bit} ^ k0 ^ tmp;
      return {y ^ f ^ k0, x, k4, st[63:16]};
   endfunction

   logic [95:0] r_in;
   logic [95:0] r_st   [NumStages];
   logic [95:0] w_next [NumStages];
   logic [31:0] r_out;
   logic        w_unused_keys;

   // Input register: plaintext and key pack directly into {x, y, k3..k0}
   always_ff @(posedge clk) begin
      if (reset) r_in <= '0;
      else       r_in <= {plaintext, key};
   end

   // Combinational rounds for each stage; round index is fixed per stage
   for (genvar s = 0; s < NumStages; s++) begin : g_stage
      logic [95:0] w_ch [c_ROUNDS_PER_STAGE+1];

      if (s == 0) begin : g_src_in
         assign w_ch[0] = r_in;
      end else begin : g_src_prev
         assign w_ch[0] = r_st[s-1];
      end

      for (genvar r = 0; r < c_ROUNDS_PER_STAGE; r++) begin : g_round
         localparam int c_RIDX = s * c_ROUNDS_PER_STAGE + r;
         assign w_ch[r+1] = round_step(w_ch[r], c_Z0[61-c_RIDX]);
      end

      assign w_next[s] = w_ch[c_ROUNDS_PER_STAGE];
   end

   // Stage register banks
   always_ff @(posedge clk) begin
      for (int s = 0; s < NumStages; s++) begin
         if (reset) r_st[s] <= '0;
         else       r_st[s] <= w_next[s];
      end
   end

   // Output register keeps only the data half of the final state
   always_ff @(posedge clk) begin
      if (reset) r_out <= '0;
      else       r_out <= r_st[NumStages-1][95:64];
   end

   // The key window leaving the last stage has no consumer
   assign w_unused_keys = ^r_st[NumStages-1][63:0];

   assign ciphertext = r_out;

endmodule
`default_nettype wire

// File: tb/tb_simon32_64_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_simon32_64_pipe
// Description : Self-checking bench for simon32_64_pipe. Three instances
//               (NumStages = 1, 4, 32) share one input stream; each output is
//               compared to a loop-based SIMON 32/64 model at its own latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_simon32_64_pipe;

   localparam int c_NDUT  = 3;
   localparam int c_HIST  = 2048;
   localparam logic [31:0] c_KAT_PT  = 32'h6565_6877;
   localparam logic [63:0] c_KAT_KEY = 64'h1918_1110_0908_0100;
   localparam logic [31:0] c_KAT_CT  = 32'hC69B_E9BB;

   logic        clk_tb = 1'b0;
   logic        reset;
   logic [31:0] plaintext;
   logic [63:0] key;
   logic [31:0] ct [c_NDUT];

   int c_lat [c_NDUT] = '{2, 5, 33};

   string z0 = "11111010001001010110000111001101111101000100101011000011100110";

   logic        hist_rst [c_HIST];
   logic [31:0] hist_pt  [c_HIST];
   logic [63:0] hist_key [c_HIST];
   int          edge_cnt = 0;

   int n_checks = 0;
   int n_errors = 0;

   simon32_64_pipe #(.NumStages(1))  u_dut1  (.clk(clk_tb), .reset(reset), .plaintext(plaintext), .key(key), .ciphertext(ct[0]));
   simon32_64_pipe #(.NumStages(4))  u_dut4  (.clk(clk_tb), .reset(reset), .plaintext(plaintext), .key(key), .ciphertext(ct[1]));
   simon32_64_pipe #(.NumStages(32)) u_dut32 (.clk(clk_tb), .reset(reset), .plaintext(plaintext), .key(key), .ciphertext(ct[2]));

   always #5 clk_tb = ~clk_tb;

   // Record what every rising edge sampled
   always @(posedge clk_tb) begin
      hist_rst[edge_cnt] = reset;
      hist_pt[edge_cnt]  = plaintext;
      hist_key[edge_cnt] = key;
      edge_cnt = edge_cnt + 1;
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] rotl(input logic [15:0] v, input int j);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < j; i++) r = {r[14:0], r[15]};
      return r;
   endfunction

   function automatic logic [31:0] simon_ref(input logic [31:0] pt, input logic [63:0] k_in);
      logic [15:0] k [32];
      logic [15:0] x, y, tmp, old_x;
      logic        zb;
      for (int i = 0; i < 4; i++) k[i] = k_in[16*i +: 16];
      for (int i = 0; i < 28; i++) begin
         zb  = (z0.getc(i) == 8'h31);
         tmp = rotl(k[i+3], 16 - 3) ^ k[i+1];
         tmp = tmp ^ rotl(tmp, 16 - 1);
         k[i+4] = 16'hFFFC ^ {15'd0, zb} ^ k[i] ^ tmp;
      end
      x = pt[31:16];
      y = pt[15:0];
      for (int i = 0; i < 32; i++) begin
         old_x = x;
         x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ k[i];
         y = old_x;
      end
      return {x, y};
   endfunction

   // Expected output after the latest edge for a given latency: {valid, value}
   function automatic logic [32:0] model_out(input int lat);
      int n;
      n = edge_cnt - 1;
      if (hist_rst[n]) return {1'b1, 32'h0};
      if (n - lat < 0) return 33'h0;
      for (int j = n - lat; j <= n; j++)
         if (hist_rst[j]) return 33'h0;
      return {1'b1, simon_ref(hist_pt[n-lat], hist_key[n-lat])};
   endfunction

   task automatic cycle();
      @(posedge clk_tb);
      #1;
   endtask

   task automatic drive_random();
      plaintext = $urandom;
      key       = {$urandom, $urandom};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      drive_random();
      for (int c = 0; c < 2; c++) begin
         cycle();
         for (int d = 0; d < c_NDUT; d++) begin
            n_checks++;
            if (ct[d] !== 32'h0) begin
               n_errors++;
               $display("FAIL reset dut%0d edge %0d: got %h expected %h", d, edge_cnt-1, ct[d], 32'h0);
            end
         end
      end
   endtask

   task automatic test_kat();
      int s;
      logic [32:0] m;
      reset     = 1'b0;
      plaintext = c_KAT_PT;
      key       = c_KAT_KEY;
      cycle();
      s = edge_cnt - 1;
      for (int c = 0; c < 34; c++) begin
         drive_random();
         cycle();
         for (int d = 0; d < c_NDUT; d++) begin
            if (edge_cnt - 1 == s + c_lat[d]) begin
               n_checks++;
               if (ct[d] !== c_KAT_CT) begin
                  n_errors++;
                  $display("FAIL kat dut%0d edge %0d: got %h expected %h", d, edge_cnt-1, ct[d], c_KAT_CT);
               end
            end
            m = model_out(c_lat[d]);
            if (m[32]) begin
               n_checks++;
               if (ct[d] !== m[31:0]) begin
                  n_errors++;
                  $display("FAIL kat_model dut%0d edge %0d: got %h expected %h", d, edge_cnt-1, ct[d], m[31:0]);
               end
            end
         end
      end
   endtask

   task automatic test_stream(input int count, input string name);
      logic [32:0] m;
      reset = 1'b0;
      for (int c = 0; c < count + 34; c++) begin
         drive_random();
         cycle();
         for (int d = 0; d < c_NDUT; d++) begin
            m = model_out(c_lat[d]);
            if (m[32]) begin
               n_checks++;
               if (ct[d] !== m[31:0]) begin
                  n_errors++;
                  $display("FAIL %s dut%0d edge %0d: got %h expected %h", name, d, edge_cnt-1, ct[d], m[31:0]);
               end
            end
         end
      end
   endtask

   task automatic test_midreset();
      logic [32:0] m;
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         drive_random();
         cycle();
      end
      reset = 1'b1;
      drive_random();
      cycle();
      for (int d = 0; d < c_NDUT; d++) begin
         n_checks++;
         if (ct[d] !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_zero dut%0d edge %0d: got %h expected %h", d, edge_cnt-1, ct[d], 32'h0);
         end
      end
      reset = 1'b0;
      for (int c = 0; c < 94; c++) begin
         drive_random();
         cycle();
         for (int d = 0; d < c_NDUT; d++) begin
            m = model_out(c_lat[d]);
            if (m[32]) begin
               n_checks++;
               if (ct[d] !== m[31:0]) begin
                  n_errors++;
                  $display("FAIL midreset dut%0d edge %0d: got %h expected %h", d, edge_cnt-1, ct[d], m[31:0]);
               end
            end
         end
      end
   endtask

   task automatic test_hold();
      reset     = 1'b0;
      plaintext = c_KAT_PT;
      key       = c_KAT_KEY;
      for (int c = 0; c < 50; c++) begin
         cycle();
         for (int d = 0; d < c_NDUT; d++) begin
            if (c >= c_lat[d]) begin
               n_checks++;
               if (ct[d] !== c_KAT_CT) begin
                  n_errors++;
                  $display("FAIL hold dut%0d edge %0d: got %h expected %h", d, edge_cnt-1, ct[d], c_KAT_CT);
               end
            end
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      plaintext = '0;
      key       = '0;
      test_reset();
      test_kat();
      test_stream(1000, "stream");
      test_midreset();
      test_hold();
      test_reset();
      test_kat();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
